lbdr_route_unit: RTL and testbench

//  Parametrised LBDR route computation for one router input port, generalising mesh size. Adds runtime config

---
 rtl/lbdr_route_unit_if.sv | 25 ++
 rtl/lbdr_route_unit.sv | 160 ++++++++++++++++
 tb/tb_lbdr_route_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbdr_route_unit_if.sv
// Flit-side and allocator-side handshake bundle for the LBDR route unit.
// master drives flits and out_ready; slave is the route unit.
interface lbdr_route_unit_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        flit_id;
    logic [ADDR_W-1:0] dst_addr;
    logic [3:0]        cong;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_port;
    logic              route_err;

    modport master (
        output in_valid, flit_id, dst_addr, cong, out_ready,
        input  in_ready, out_valid, out_port, route_err
    );

    modport slave (
        input  in_valid, flit_id, dst_addr, cong, out_ready,
        output in_ready, out_valid, out_port, route_err
    );
endinterface

// File: rtl/lbdr_route_unit.sv
// LBDR route computation for one router input port: per-packet route lock,
// runtime config, fixed-priority or congestion-aware candidate selection.
module lbdr_route_unit #(
    parameter int unsigned X_W      = 2,
    parameter int unsigned Y_W      = 2,
    parameter int unsigned ADAPTIVE = 0,
    parameter logic [7:0]  RXY_DEF  = 8'd60,
    parameter logic [3:0]  CX_DEF   = 4'd15,
    parameter int unsigned CUR_DEF  = 5,
    parameter logic [2:0]  HDR_ID   = 3'b001,
    parameter logic [2:0]  BODY_ID  = 3'b010,
    parameter logic [2:0]  TAIL_ID  = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_rxy,
    input  logic [3:0]           cfg_cx,
    input  logic [X_W+Y_W-1:0]   cfg_cur_addr,
    lbdr_route_unit_if.slave     bus
);
    localparam int unsigned ADDR_W = X_W + Y_W;

    typedef enum logic [1:0] {StIdle, StLock, StDrop} state_e;

    state_e            state_q, state_d;
    logic [7:0]        rxy_q;
    logic [3:0]        cx_q;
    logic [ADDR_W-1:0] cur_q;
    logic              rr_q, rr_d;
    logic [4:0]        lock_q, lock_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_port_q, out_port_d;
    logic              err_q, err_d;

    logic [X_W-1:0] x_dst, x_cur;
    logic [Y_W-1:0] y_dst, y_cur;
    logic           n1, s1, e1, w1, is_local, multi, accept, emit;
    logic [3:0]     cand, free, sel;
    logic [4:0]     route_port, emit_port;

    assign x_dst = bus.dst_addr[X_W-1:0];
    assign y_dst = bus.dst_addr[ADDR_W-1:X_W];
    assign x_cur = cur_q[X_W-1:0];
    assign y_cur = cur_q[ADDR_W-1:X_W];

    assign n1 = y_dst < y_cur;
    assign s1 = y_dst > y_cur;
    assign e1 = x_dst > x_cur;
    assign w1 = x_dst < x_cur;
    assign is_local = ~n1 & ~s1 & ~e1 & ~w1;

    // Candidate bit order {S,W,E,N} matches both cong and the low bits of out_port.
    assign cand[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
    assign cand[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
    assign cand[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
    assign cand[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];
    assign multi   = (cand & (cand - 4'd1)) != 4'd0;

    // At most one vertical and one horizontal candidate can exist at a time.
    always_comb begin
        sel  = 4'b0000;
        free = cand & ~bus.cong;
        if (free == 4'b0000) begin
            free = cand;
        end
        if (ADAPTIVE == 0) begin
            if (cand[0])      sel = 4'b0001;
            else if (cand[1]) sel = 4'b0010;
            else if (cand[2]) sel = 4'b0100;
            else if (cand[3]) sel = 4'b1000;
        end else if ((free & 4'b1001) != 4'b0000 && (free & 4'b0110) != 4'b0000) begin
            sel = rr_q ? (free & 4'b0110) : (free & 4'b1001);
        end else begin
            sel = free;
        end
    end

    assign route_port = is_local ? 5'b10000 : {1'b0, sel};
    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        rr_d      = rr_q;
        err_d     = 1'b0;
        emit      = 1'b0;
        emit_port = lock_q;
        if (accept) begin
            case (bus.flit_id)
                HDR_ID: begin
                    err_d = (state_q == StLock);
                    if (multi) rr_d = ~rr_q;
                    if (route_port != 5'b00000) begin
                        state_d   = StLock;
                        lock_d    = route_port;
                        emit      = 1'b1;
                        emit_port = route_port;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
                BODY_ID: begin
                    if (state_q == StLock)      emit  = 1'b1;
                    else if (state_q == StIdle) err_d = 1'b1;
                end
                TAIL_ID: begin
                    if (state_q == StLock) emit = 1'b1;
                    if (state_q == StIdle) err_d   = 1'b1;
                    else                   state_d = StIdle;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_port_d  = out_port_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_port_d  = emit_port;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_port_d  = 5'b00000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxy_q       <= RXY_DEF;
            cx_q        <= CX_DEF;
            cur_q       <= ADDR_W'(CUR_DEF);
            state_q     <= StIdle;
            lock_q      <= 5'b00000;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_port_q  <= 5'b00000;
            err_q       <= 1'b0;
        end else begin
            if (cfg_we) begin
                rxy_q <= cfg_rxy;
                cx_q  <= cfg_cx;
                cur_q <= cfg_cur_addr;
            end
            state_q     <= state_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_port_q  <= out_port_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.route_err = err_q;
endmodule

// File: tb/tb_lbdr_route_unit.sv
// Bench for lbdr_route_unit: fixed-priority and adaptive instances share stimulus,
// directed scenarios plus a random run against a packet-level reference model.
module tb_lbdr_route_unit;
    localparam logic [2:0] HDR = 3'b001, BODY = 3'b010, TAIL = 3'b100;
    localparam logic [4:0] P_N = 5'b00001, P_E = 5'b00010, P_W = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000, P_L = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    logic cfg_we;
    logic [7:0] cfg_rxy;
    logic [3:0] cfg_cx, cfg_cur;
    logic in_valid, out_ready;
    logic [2:0] flit_id;
    logic [3:0] dst, cong;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lbdr_route_unit_if #(.ADDR_W(4)) bus0 ();
    lbdr_route_unit_if #(.ADDR_W(4)) bus1 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
    assign bus0.flit_id = flit_id;    assign bus1.flit_id = flit_id;
    assign bus0.dst_addr = dst;       assign bus1.dst_addr = dst;
    assign bus0.cong = cong;          assign bus1.cong = cong;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    lbdr_route_unit #(.ADAPTIVE(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
        .cfg_cur_addr(cfg_cur), .bus(bus0)
    );
    lbdr_route_unit #(.ADAPTIVE(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
        .cfg_cur_addr(cfg_cur), .bus(bus1)
    );

    // Reference model state (packet level)
    logic [7:0] m_rxy;
    logic [3:0] m_cx, m_cur;
    int         m_st;  // 0 idle, 1 locked, 2 dropping
    logic [4:0] m_lock0, m_lock1;
    bit         m_rr, m_err;
    logic [4:0] q0[$], q1[$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] id, input logic [3:0] d,
                         input logic [3:0] c, input bit ordy);
        in_valid = v; flit_id = id; dst = d; cong = c; out_ready = ordy;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; cfg_we = 1'b0;
        #1 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic load_cfg(input logic [7:0] rxy, input logic [3:0] cx, input logic [3:0] cur);
        in_valid = 1'b0; cfg_we = 1'b1; cfg_rxy = rxy; cfg_cx = cx; cfg_cur = cur;
        tick();
        cfg_we = 1'b0;
    endtask

    // Index into Rxy of the turn permission for leaving in dir a while also needing dir b.
    function automatic int turn_bit(input int a, input int b);
        case (a)
            0:       return (b == 1) ? 0 : 1;
            1:       return (b == 0) ? 2 : 3;
            2:       return (b == 0) ? 4 : 5;
            default: return (b == 1) ? 6 : 7;
        endcase
    endfunction

    function automatic void model_route(input logic [7:0] rxy, input logic [3:0] cx,
        input logic [3:0] cur, input logic [3:0] d, input logic [3:0] c, input bit rr,
        output logic [4:0] p0, output logic [4:0] p1, output bit multi);
        int xc = int'(cur[1:0]), yc = int'(cur[3:2]);
        int xd = int'(d[1:0]), yd = int'(d[3:2]);
        int v = (yd < yc) ? 0 : (yd > yc) ? 3 : -1;
        int h = (xd > xc) ? 1 : (xd < xc) ? 2 : -1;
        logic [3:0] cand = 4'b0000;
        logic [3:0] filt;
        p0 = 5'b00000; p1 = 5'b00000; multi = 1'b0;
        if (v < 0 && h < 0) begin
            p0 = P_L; p1 = P_L;
            return;
        end
        if (h < 0)      cand[v] = cx[v];
        else if (v < 0) cand[h] = cx[h];
        else begin
            cand[v] = cx[v] & rxy[turn_bit(v, h)];
            cand[h] = cx[h] & rxy[turn_bit(h, v)];
        end
        multi = ($countones(cand) == 2);
        for (int i = 3; i >= 0; i--) if (cand[i]) p0 = 5'(1 << i);
        filt = cand & ~c;
        if (filt == 4'b0000) filt = cand;
        if ($countones(filt) == 2) p1 = rr ? 5'(1 << h) : 5'(1 << v);
        else                       p1 = {1'b0, filt};
    endfunction

    function automatic void model_accept(input logic [2:0] id, input logic [3:0] d,
                                         input logic [3:0] c);
        logic [4:0] p0, p1;
        bit multi;
        case (id)
            HDR: begin
                if (m_st == 1) m_err = 1'b1;
                model_route(m_rxy, m_cx, m_cur, d, c, m_rr, p0, p1, multi);
                if (multi) m_rr = ~m_rr;
                if (p0 != 5'b00000) begin
                    m_st = 1; m_lock0 = p0; m_lock1 = p1;
                    q0.push_back(p0); q1.push_back(p1);
                end else begin
                    m_err = 1'b1; m_st = 2;
                end
            end
            BODY: begin
                if (m_st == 1) begin q0.push_back(m_lock0); q1.push_back(m_lock1); end
                else if (m_st == 0) m_err = 1'b1;
            end
            TAIL: begin
                if (m_st == 1) begin q0.push_back(m_lock0); q1.push_back(m_lock1); end
                if (m_st == 0) m_err = 1'b1;
                else m_st = 0;
            end
            default: m_err = 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        drive(0, HDR, 4'd0, 4'd0, 1'b1);
        cfg_we = 1'b0; cfg_rxy = 8'd0; cfg_cx = 4'd0; cfg_cur = 4'd0;
        rst = 1'b0;
        #3;
        total++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_out_valid got=%b/%b exp=0", bus0.out_valid, bus1.out_valid); end
        total++; if (bus0.out_port !== 5'b0 || bus1.out_port !== 5'b0) begin bad++;
            $display("FAIL reset_out_port got=%b/%b exp=00000", bus0.out_port, bus1.out_port); end
        total++; if (bus0.route_err !== 1'b0 || bus0.in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_err_ready got=%b/%b exp=0/1", bus0.route_err, bus0.in_ready); end
        #4 rst = 1'b1;
        tick();
    endtask

    task automatic test_local();
        drive(1, HDR, 4'd5, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_valid !== 1'b1 || bus0.out_port !== P_L || bus1.out_port !== P_L)
            begin bad++; $display("FAIL local_hdr got=%b %b/%b exp=1 %b", bus0.out_valid,
                bus0.out_port, bus1.out_port, P_L); end
        drive(1, BODY, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_port !== P_L || bus1.out_port !== P_L) begin bad++;
            $display("FAIL local_body got=%b/%b exp=%b", bus0.out_port, bus1.out_port, P_L); end
        drive(1, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_valid !== 1'b1 || bus0.out_port !== P_L) begin bad++;
            $display("FAIL local_tail got=%b %b exp=1 %b", bus0.out_valid, bus0.out_port, P_L); end
        drive(1, BODY, 4'd5, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b1 || bus0.out_valid !== 1'b0) begin bad++;
            $display("FAIL idle_body got err=%b valid=%b exp=1 0", bus0.route_err, bus0.out_valid); end
        drive(0, BODY, 4'd5, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b0 || bus1.route_err !== 1'b0) begin bad++;
            $display("FAIL err_pulse got=%b/%b exp=0", bus0.route_err, bus1.route_err); end
    endtask

    task automatic test_nw();
        drive(1, HDR, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_port !== P_W || bus1.out_port !== P_W) begin bad++;
            $display("FAIL nw_port got=%b/%b exp=%b", bus0.out_port, bus1.out_port, P_W); end
        drive(1, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_adaptive();
        logic [4:0] exp1[3] = '{P_E, P_S, P_E};
        logic [3:0] cg[3]   = '{4'b1000, 4'b0000, 4'b0000};
        do_reset();
        load_cfg(8'hFF, 4'hF, 4'd5);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin do_reset(); load_cfg(8'hFF, 4'hF, 4'd5); end
            drive(1, HDR, 4'd15, cg[i], 1'b1);
            tick();
            total++; if (bus1.out_port !== exp1[i] || bus0.out_port !== P_E) begin bad++;
                $display("FAIL adaptive_%0d got=%b/%b exp=%b/%b", i, bus0.out_port,
                    bus1.out_port, P_E, exp1[i]); end
            drive(1, TAIL, 4'd0, 4'd0, 1'b1);
            tick();
        end
        // Header and config load on the same edge: header must use the old Rxy.
        cfg_we = 1'b1; cfg_rxy = 8'd60; cfg_cx = 4'hF; cfg_cur = 4'd5;
        drive(1, HDR, 4'd0, 4'd0, 1'b1);
        tick();
        cfg_we = 1'b0;
        total++; if (bus0.out_port !== P_N) begin bad++;
            $display("FAIL cfg_old_hdr got=%b exp=%b", bus0.out_port, P_N); end
        drive(1, BODY, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_port !== P_N) begin bad++;
            $display("FAIL cfg_locked_body got=%b exp=%b", bus0.out_port, P_N); end
        drive(1, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
        drive(1, HDR, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_port !== P_W || bus1.out_port !== P_W) begin bad++;
            $display("FAIL cfg_new_hdr got=%b/%b exp=%b", bus0.out_port, bus1.out_port, P_W); end
        drive(1, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_unroutable();
        do_reset();
        load_cfg(8'd60, 4'b1101, 4'd5);
        drive(1, HDR, 4'd7, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b1 || bus1.route_err !== 1'b1 || bus0.out_valid !== 1'b0)
            begin bad++; $display("FAIL unroute_hdr got err=%b/%b valid=%b exp=1 0",
                bus0.route_err, bus1.route_err, bus0.out_valid); end
        drive(1, BODY, 4'd7, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b0 || bus0.out_valid !== 1'b0) begin bad++;
            $display("FAIL drop_body got err=%b valid=%b exp=0 0", bus0.route_err, bus0.out_valid); end
        drive(1, TAIL, 4'd7, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b0 || bus1.out_valid !== 1'b0) begin bad++;
            $display("FAIL drop_tail got err=%b valid=%b exp=0 0", bus0.route_err, bus1.out_valid); end
        drive(1, BODY, 4'd7, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b1) begin bad++;
            $display("FAIL drop_to_idle got err=%b exp=1", bus0.route_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, HDR, 4'd0, 4'd0, 1'b0);
        tick();
        drive(1, BODY, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++; if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1 || bus0.out_port !== P_W)
                begin bad++; $display("FAIL stall_%0d got rdy=%b valid=%b port=%b exp=0 1 %b", i,
                    bus0.in_ready, bus0.out_valid, bus0.out_port, P_W); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (bus0.in_ready !== 1'b1) begin bad++;
            $display("FAIL release_ready got=%b exp=1", bus0.in_ready); end
        tick();
        total++; if (bus0.out_valid !== 1'b1 || bus0.out_port !== P_W || bus0.route_err !== 1'b0)
            begin bad++; $display("FAIL release_body got valid=%b port=%b exp=1 %b",
                bus0.out_valid, bus0.out_port, P_W); end
        drive(1, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
        drive(0, TAIL, 4'd0, 4'd0, 1'b1);
        tick();
        total++; if (bus0.out_valid !== 1'b0) begin bad++;
            $display("FAIL drain got valid=%b exp=0", bus0.out_valid); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(1, HDR, 4'd5, 4'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        total++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin bad++;
            $display("FAIL async_clear got=%b/%b exp=0", bus0.out_valid, bus1.out_valid); end
        rst = 1'b1;
        drive(1, BODY, 4'd5, 4'd0, 1'b1);
        tick();
        total++; if (bus0.route_err !== 1'b1 || bus0.out_valid !== 1'b0) begin bad++;
            $display("FAIL post_reset_body got err=%b valid=%b exp=1 0",
                bus0.route_err, bus0.out_valid); end
        drive(0, BODY, 4'd5, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [2:0] unk;
        bit exp_rdy, acc;
        int r;
        do_reset();
        m_st = 0; m_rr = 1'b0; m_err = 1'b0; q0.delete(); q1.delete();
        m_rxy = 8'($urandom); m_cx = 4'($urandom); m_cur = 4'($urandom);
        load_cfg(m_rxy, m_cx, m_cur);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            total++; if (bus0.route_err !== m_err || bus1.route_err !== m_err) begin bad++;
                $display("FAIL rnd_err cyc=%0d got=%b/%b exp=%b", cyc, bus0.route_err,
                    bus1.route_err, m_err); end
            total++; if (bus0.out_valid !== (q0.size() != 0) || bus1.out_valid !== (q1.size() != 0))
                begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%0d", cyc,
                    bus0.out_valid, bus1.out_valid, q0.size()); end
            if (q0.size() != 0) begin
                total++; if (bus0.out_port !== q0[0] || bus1.out_port !== q1[0]) begin bad++;
                    $display("FAIL rnd_port cyc=%0d got=%b/%b exp=%b/%b", cyc, bus0.out_port,
                        bus1.out_port, q0[0], q1[0]); end
            end
            r = $urandom_range(0, 99);
            unk = 3'($urandom_range(0, 2));
            flit_id = (r < 30) ? HDR : (r < 65) ? BODY : (r < 90) ? TAIL :
                      (unk == 0) ? 3'b000 : (unk == 1) ? 3'b011 : 3'b111;
            in_valid = ($urandom_range(0, 9) < 8);
            dst = 4'($urandom); cong = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_rxy = 8'($urandom); cfg_cx = 4'($urandom); cfg_cur = 4'($urandom);
            #1;
            exp_rdy = (q0.size() == 0) || out_ready;
            total++; if (bus0.in_ready !== exp_rdy || bus1.in_ready !== exp_rdy) begin bad++;
                $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", cyc, bus0.in_ready,
                    bus1.in_ready, exp_rdy); end
            acc = in_valid && exp_rdy;
            if (q0.size() != 0 && out_ready) begin void'(q0.pop_front()); void'(q1.pop_front()); end
            m_err = 1'b0;
            if (acc) model_accept(flit_id, dst, cong);
            if (cfg_we) begin m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur = cfg_cur; end
            @(posedge clk); #1;
        end
        cfg_we = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_local();
        test_nw();
        test_adaptive();
        test_unroutable();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
